mapa_bank_writer: RTL and testbench
===================================

Name: mapa_bank_writer

Overview:
- Write-side counterpart of the 8-way map-row read multiplexer. Holds eight 7-bit map rows (mapa0..mapa7) in registers and presents all eight in parallel, ready to drive the read mux's row inputs.
- Loads rows over a valid/ready write port. Supports explicit addressing or auto-increment fill.
- Provides a self-timed clear sequence that refills the bank with a fixed pattern.

Parameters:
- WIDTH, 7, bits per map row.
- CLEAR_VAL, 7'b0000000, pattern written to every row by the clear sequence.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request; wr_data/wr_addr/wr_auto stable while high.
- wr_ready  out  1  bank can accept a write this cycle.
- wr_data  in  WIDTH  row value to store.
- wr_addr  in  3  target row when wr_auto=0.
- wr_auto  in  1  1 = write to internal pointer, then increment it.
- clear  in  1  start the clear sequence (level sampled in IDLE).
- busy  out  1  clear sequence in progress.
- fill_done  out  1  one-cycle pulse: auto write to row 7 accepted.
- ptr  out  3  current auto-increment pointer.
- mapa0..mapa7  out  WIDTH each  stored rows, registered outputs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - mapa0..mapa7 = 0, ptr = 0, state = IDLE, busy = 0, fill_done = 0.
  - wr_ready = 0 while rst_n is low.
- States: IDLE, CLEAR.
- wr_ready is combinational: 1 iff state==IDLE, clear==0 and rst_n==1.
- A write is accepted on a clock edge when wr_valid & wr_ready.
  - The target row updates at that edge and is visible on mapaN the next cycle (latency 1).
  - All other rows hold.
- wr_auto=0: target row = wr_addr; ptr unchanged.
- wr_auto=1: target row = ptr; ptr <= ptr+1 mod 8 (7 wraps to 0).
  - If the accepted write targeted ptr==7, fill_done = 1 for exactly the following cycle.
- IDLE with clear==1:
  - Next state CLEAR; internal clear index cidx <= 0; busy = 1 from the next cycle.
  - A wr_valid in the same cycle is NOT accepted (clear wins; wr_ready is 0).
- CLEAR:
  - Each cycle: mapa[cidx] <= CLEAR_VAL; cidx <= cidx+1.
  - After writing cidx==7: ptr <= 0, state <= IDLE, busy deasserts.
  - Sequence is exactly 8 cycles with busy high.
  - clear asserted during CLEAR is ignored (no restart).
  - wr_ready = 0 throughout; writes are not accepted.
  - fill_done is never asserted in CLEAR.
- clear held high continuously: after a sequence ends, one IDLE cycle occurs with wr_ready=0 (clear high), then a new sequence starts.
- Reset mid-CLEAR: all rows go to 0 immediately, state IDLE; the partial clear is abandoned.
- wr_addr is ignored when wr_auto=1; wr_data is never modified or truncated (full WIDTH stored).
- Mixing modes is legal: explicit writes do not disturb ptr.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> all mapaN = 7'b0000000, ptr=0, wr_ready=0 during reset and 1 after release with clear=0.
- Explicit write: wr_auto=0, wr_addr=5, wr_data=7'b1111110, one valid cycle -> next cycle mapa5=7'b1111110, all others 0, ptr=0.
- Auto fill:
  - Stimulus: 8 back-to-back valid cycles, wr_auto=1, data 7'b1000001, 1100011, 1110111, 1111001, 1111101, 1111110, 1111111, 0111111.
  - Required: mapa0..mapa7 equal those values in order; fill_done high for one cycle after the 8th accept; ptr wraps to 0.
  - Extension: a 9th auto write of 7'b0000001 lands in mapa0.
- Clear vs write collision:
  - Stimulus: bank filled with a nonzero pattern; clear=1 and wr_valid=1 in the same IDLE cycle, then clear=0.
  - Required: the write is not accepted; busy high for exactly 8 cycles; each row becomes CLEAR_VAL one per cycle, mapa0 first; ptr=0 and wr_ready=1 afterwards.
- Clear re-trigger and reset abort:
  - Stimulus: clear pulsed again during CLEAR.
  - Required: ignored; the sequence still ends at 8 cycles.
  - Stimulus: rst_n pulsed low at clear cycle 3 with rows 3..7 still nonzero.
  - Required: all rows 0 immediately, busy=0.
- Mode mixing:
  - Stimulus: auto writes to rows 0 and 1 (ptr=2), then an explicit write wr_addr=6, data 7'b0101010, then an auto write of 7'b0011100.
  - Required: mapa6=7'b0101010, mapa2=7'b0011100, ptr=3.

Source files
------------

// File: rtl/mapa_bank_writer.sv
// mapa_bank_writer: eight-row map bank with a valid/ready write port and self-timed clear
module mapa_bank_writer #(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       wr_addr,
  input  logic             wr_auto,
  input  logic             clear,
  output logic             busy,
  output logic             fill_done,
  output logic [2:0]       ptr,
  output logic [WIDTH-1:0] mapa0,
  output logic [WIDTH-1:0] mapa1,
  output logic [WIDTH-1:0] mapa2,
  output logic [WIDTH-1:0] mapa3,
  output logic [WIDTH-1:0] mapa4,
  output logic [WIDTH-1:0] mapa5,
  output logic [WIDTH-1:0] mapa6,
  output logic [WIDTH-1:0] mapa7
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [2:0] cidx;
  logic [WIDTH-1:0] rows [8];
  assign wr_ready = rst_n && state == IDLE && !clear;
  assign busy = state == CLEAR;
  assign {mapa0, mapa1, mapa2, mapa3} = {rows[0], rows[1], rows[2], rows[3]};
  assign {mapa4, mapa5, mapa6, mapa7} = {rows[4], rows[5], rows[6], rows[7]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rows[i] <= '0;
      state <= IDLE;
      cidx <= '0;
      ptr <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (state == IDLE) begin
        // clear has priority over a same-cycle write
        if (clear) begin
          state <= CLEAR;
          cidx <= '0;
        end else if (wr_valid) begin
          rows[wr_auto ? ptr : wr_addr] <= wr_data;
          if (wr_auto) begin
            ptr <= ptr + 3'd1;
            fill_done <= ptr == 3'd7;
          end
        end
      end else begin
        rows[cidx] <= CLEAR_VAL;
        cidx <= cidx + 3'd1;
        if (cidx == 3'd7) begin
          ptr <= '0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mapa_bank_writer.sv
// tb_mapa_bank_writer: directed checks of write, auto-fill, clear and reset-abort behaviour
module tb_mapa_bank_writer;
  logic clk = 0, rst_n = 0, wr_valid = 0, wr_auto = 0, clear = 0;
  logic [6:0] wr_data = '0;
  logic [2:0] wr_addr = '0;
  logic wr_ready, busy, fill_done;
  logic [2:0] ptr;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4, mapa5, mapa6, mapa7;
  logic [6:0] m [8];
  logic [6:0] exp_rows [8];
  logic [6:0] fill [8];
  int passed = 0, total = 0;
  mapa_bank_writer dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_auto(wr_auto), .clear(clear),
    .busy(busy), .fill_done(fill_done), .ptr(ptr),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3),
    .mapa4(mapa4), .mapa5(mapa5), .mapa6(mapa6), .mapa7(mapa7)
  );
  assign m = '{mapa0, mapa1, mapa2, mapa3, mapa4, mapa5, mapa6, mapa7};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic auto_, input logic [2:0] addr, input logic [6:0] data);
    wr_valid = 1; wr_auto = auto_; wr_addr = addr; wr_data = data;
    step();
    wr_valid = 0;
    if (auto_) exp_rows[3'(ptr - 3'd1)] = data;
    else exp_rows[addr] = data;
  endtask
  task automatic chk_rows(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_row%0d", tag, i), m[i], exp_rows[i]);
  endtask
  initial begin
    int n;
    fill = '{7'b1000001, 7'b1100011, 7'b1110111, 7'b1111001,
             7'b1111101, 7'b1111110, 7'b1111111, 7'b0111111};
    for (int i = 0; i < 8; i++) exp_rows[i] = '0;
    step(); step();
    chk_rows("reset");
    chk("reset_ptr", ptr, 0);
    chk("reset_ready", wr_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fill_done", fill_done, 0);
    rst_n = 1;
    #1 chk("idle_ready", wr_ready, 1);
    wr(0, 3'd5, 7'b1111110);
    chk("explicit_row5", mapa5, 7'b1111110);
    chk_rows("explicit");
    chk("explicit_ptr", ptr, 0);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_auto = 1; wr_addr = 3'd2; wr_data = fill[i];
      step();
      if (i < 7) chk($sformatf("fill_done_early%0d", i), fill_done, 0);
    end
    wr_valid = 0;
    for (int i = 0; i < 8; i++) exp_rows[i] = fill[i];
    chk("fill_done_pulse", fill_done, 1);
    chk("fill_ptr_wrap", ptr, 0);
    chk_rows("autofill");
    step();
    chk("fill_done_once", fill_done, 0);
    wr(1, 3'd4, 7'b0000001);
    chk("ninth_row0", mapa0, 7'b0000001);
    chk("ninth_ptr", ptr, 1);
    chk("ninth_fill_done", fill_done, 0);
    clear = 1; wr_valid = 1; wr_auto = 0; wr_addr = 3'd3; wr_data = 7'b0000000;
    #1 chk("collide_ready", wr_ready, 0);
    step();
    clear = 0; wr_valid = 0;
    chk("collide_no_write", mapa3, exp_rows[3]);
    chk("collide_busy", busy, 1);
    chk("clear_ready", wr_ready, 0);
    n = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_rows[k] = '0;
      chk($sformatf("clear_row%0d", k), m[k], 0);
      if (k < 7) chk($sformatf("clear_next%0d", k), m[k + 1], exp_rows[k + 1]);
      if (busy) n++;
    end
    chk("clear_busy_cycles", n, 8);
    chk("clear_done_busy", busy, 0);
    chk("clear_ptr", ptr, 0);
    chk("clear_ready_after", wr_ready, 1);
    clear = 1;
    step();
    clear = 0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      n++;
      clear = (c == 3);
      step();
    end
    clear = 0;
    chk("retrigger_busy_cycles", n, 8);
    chk("retrigger_ready", wr_ready, 1);
    for (int i = 0; i < 8; i++) wr(1, 3'd0, 7'(i + 9));
    chk("refill_row7", mapa7, 7'd16);
    clear = 1;
    step();
    clear = 0;
    step(); step(); step();
    chk("abort_row2_cleared", mapa2, 0);
    chk("abort_row3_pending", mapa3, 7'd12);
    rst_n = 0;
    #1;
    for (int i = 0; i < 8; i++) exp_rows[i] = '0;
    chk_rows("abort");
    chk("abort_busy", busy, 0);
    chk("abort_ready", wr_ready, 0);
    step();
    rst_n = 1;
    #1 chk("abort_ptr", ptr, 0);
    wr(1, 3'd7, 7'b0000011);
    wr(1, 3'd7, 7'b0000101);
    chk("mix_ptr2", ptr, 2);
    wr(0, 3'd6, 7'b0101010);
    chk("mix_explicit_ptr", ptr, 2);
    wr(1, 3'd0, 7'b0011100);
    chk("mix_row6", mapa6, 7'b0101010);
    chk("mix_row2", mapa2, 7'b0011100);
    chk("mix_ptr3", ptr, 3);
    chk_rows("mix");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
